// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO write-side adapter: skid states,
// default widths and the FIFO depth helper.
package async_fifo_pkg;

    localparam int WI_DEF  = 16;
    localparam int L2D_DEF = 4;
    localparam int CW_DEF  = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    function automatic int lmax(input int l2d);
        return 1 << l2d;
    endfunction

endpackage

// File: rtl/async_fifo_wr_adapter_if.sv
// Upstream valid/ready stream plus the FIFO write port, bundled as one bus.
// slave = the adapter; master = the producer/FIFO side that drives it.
interface async_fifo_wr_adapter_if
    import async_fifo_pkg::*;
#(
    parameter int WI  = WI_DEF,
    parameter int L2D = L2D_DEF
);
    logic          s_valid;
    logic [WI-1:0] s_data;
    logic          s_ready;
    logic          w_strobe;
    logic [WI-1:0] w_data;
    logic          w_full;
    logic [L2D:0]  w_level;

    modport slave (
        input  s_valid, s_data, w_full, w_level,
        output s_ready, w_strobe, w_data
    );

    modport master (
        output s_valid, s_data, w_full, w_level,
        input  s_ready, w_strobe, w_data
    );
endinterface

// File: rtl/wr_skid_buf.sv
// Two-entry ordered skid queue; e0 is always the head (oldest word).
// State encodes the entry count.
module wr_skid_buf
    import async_fifo_pkg::*;
#(
    parameter int WI = WI_DEF
) (
    input  logic          wclk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [WI-1:0] push_data,
    input  logic          pop,
    output logic [WI-1:0] head,
    output skid_state_e   state
);

    skid_state_e   state_q, state_d;
    logic [WI-1:0] e0_q, e1_q, e0_d, e1_d;

    always_ff @(posedge wclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            state_q <= state_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    e0_d    = push_data;
                end
            end
            ONE: begin
                // Simultaneous push/pop replaces the head in place.
                if (push && pop) begin
                    e0_d = push_data;
                end else if (push) begin
                    state_d = TWO;
                    e1_d    = push_data;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    e0_d    = e1_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign head  = e0_q;
    assign state = state_q;

endmodule

// File: rtl/async_fifo_wr_adapter.sv
// Write-side front end for the async FIFO: skid-buffers upstream words and
// issues registered writes only when the stale FIFO flags prove there is room.
module async_fifo_wr_adapter
    import async_fifo_pkg::*;
#(
    parameter int WI  = WI_DEF,
    parameter int L2D = L2D_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic                    wclk,
    input  logic                    reset_n,
    async_fifo_wr_adapter_if.slave  bus,
    output logic [CW-1:0]           wr_count,
    output logic [CW-1:0]           stall_count,
    output logic                    err_overrun
);

    localparam logic [L2D+1:0] LMAX = (L2D+2)'(lmax(L2D));

    skid_state_e    state;
    logic [WI-1:0]  head;
    logic           push, pop, can_write;
    logic           strobe_q;
    logic [WI-1:0]  data_q;
    logic [L2D+1:0] lvl_sum;

    // Ready comes from the state register alone so upstream sees no comb path.
    assign bus.s_ready = (state != TWO);
    assign push        = bus.s_valid & bus.s_ready;

    // w_level lags by one write; the strobe in flight is added back here.
    assign lvl_sum   = {1'b0, bus.w_level} + (L2D+2)'(strobe_q);
    assign can_write = !bus.w_full && (lvl_sum < LMAX);
    assign pop       = (state != EMPTY) && can_write;

    wr_skid_buf #(.WI(WI)) u_skid (
        .wclk      (wclk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (bus.s_data),
        .pop       (pop),
        .head      (head),
        .state     (state)
    );

    always_ff @(posedge wclk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_q <= 1'b0;
            data_q   <= '0;
        end else begin
            strobe_q <= pop;
            if (pop) data_q <= head;
        end
    end

    assign bus.w_strobe = strobe_q;
    assign bus.w_data   = data_q;

    always_ff @(posedge wclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_count    <= '0;
            stall_count <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (strobe_q) wr_count <= wr_count + CW'(1);
            if (state != EMPTY && !can_write && stall_count != '1)
                stall_count <= stall_count + CW'(1);
            if (strobe_q && bus.w_full) err_overrun <= 1'b1;
        end
    end

endmodule
